// File: rtl/irr_sync.sv
// Interrupt request register: per-channel synchroniser, edge/level capture with
// acknowledge clearing, and a rotating-priority resolver over unmasked requests.
module irr_sync #(
  parameter int N           = 8,
  parameter int SYNC_STAGES = 2,
  localparam int IDW        = (N < 2) ? 1 : $clog2(N)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   ir_in,
  input  logic [N-1:0]   level_mode,
  input  logic [N-1:0]   imr,
  input  logic [IDW-1:0] prio_base,
  input  logic           ack_valid,
  input  logic [IDW-1:0] ack_id,
  output logic [N-1:0]   irr,
  output logic           int_req,
  output logic [IDW-1:0] req_id
);

  logic [N-1:0] sync_q [SYNC_STAGES];
  logic [N-1:0] sync_s;
  logic [N-1:0] prev_q;
  logic [N-1:0] rise;
  logic [N-1:0] ack_hit;
  logic [N-1:0] irr_nxt;
  logic [N-1:0] pend;
  int           base;
  int           idx;

  assign sync_s = sync_q[SYNC_STAGES-1];
  assign rise   = sync_s & ~prev_q;

  // ack_id values >= N never match a channel, so they fall out naturally
  always_comb begin
    ack_hit = '0;
    for (int i = 0; i < N; i++) begin
      if (ack_valid && (int'(ack_id) == i)) ack_hit[i] = 1'b1;
    end
  end

  // Edge channels: set beats ack. Level channels follow the synchronised line.
  assign irr_nxt = (level_mode & sync_s) |
                   (~level_mode & (rise | (irr & ~ack_hit)));

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int j = 0; j < SYNC_STAGES; j++) sync_q[j] <= '0;
      prev_q <= '0;
      irr    <= '0;
    end else begin
      sync_q[0] <= ir_in;
      for (int j = 1; j < SYNC_STAGES; j++) sync_q[j] <= sync_q[j-1];
      prev_q <= sync_s;
      irr    <= irr_nxt;
    end
  end

  assign pend    = irr & ~imr;
  assign int_req = |pend;

  // Scan from lowest priority to highest so the last hit is the winner.
  always_comb begin
    base   = (int'(prio_base) < N) ? int'(prio_base) : 0;
    idx    = 0;
    req_id = '0;
    for (int off = N - 1; off >= 0; off--) begin
      idx = base + off;
      if (idx >= N) idx = idx - N;
      if (pend[idx[IDW-1:0]]) req_id = idx[IDW-1:0];
    end
  end

endmodule

// File: tb/tb_irr_sync.sv
// Bench for irr_sync: two instances (N=8/SS=2 and N=5/SS=3) checked every cycle
// against a behavioural model, plus directed literal expectations.
module tb_irr_sync;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [7:0] ir_a, lvl_a, imr_a, irr_a;
  logic [2:0] pb_a, aid_a, rid_a;
  logic       av_a, ireq_a;

  logic [4:0] ir_b, lvl_b, imr_b, irr_b;
  logic [2:0] pb_b, aid_b, rid_b;
  logic       av_b, ireq_b;

  irr_sync #(.N(8), .SYNC_STAGES(2)) u_a (
    .clk(clk), .reset(reset), .ir_in(ir_a), .level_mode(lvl_a), .imr(imr_a),
    .prio_base(pb_a), .ack_valid(av_a), .ack_id(aid_a),
    .irr(irr_a), .int_req(ireq_a), .req_id(rid_a)
  );

  irr_sync #(.N(5), .SYNC_STAGES(3)) u_b (
    .clk(clk), .reset(reset), .ir_in(ir_b), .level_mode(lvl_b), .imr(imr_b),
    .prio_base(pb_b), .ack_valid(av_b), .ack_id(aid_b),
    .irr(irr_b), .int_req(ireq_b), .req_id(rid_b)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Model: m_hist[k][d] is the line value sampled d+1 edges ago (zero after reset)
  logic [7:0] m_hist [2][4];
  logic [7:0] m_p    [2];
  logic [7:0] m_irr  [2];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic model_step(input int k, input int n, input int ss,
                            input logic [7:0] ir, input logic [7:0] lvl,
                            input logic av, input int aid);
    logic [7:0] s;
    logic [7:0] mask;
    mask = 8'((1 << n) - 1);
    if (reset) begin
      for (int j = 0; j < 4; j++) m_hist[k][j] = '0;
      m_p[k]   = '0;
      m_irr[k] = '0;
    end else begin
      s = m_hist[k][ss-1];
      for (int i = 0; i < n; i++) begin
        if (lvl[i])                   m_irr[k][i] = s[i];
        else if (s[i] && !m_p[k][i])  m_irr[k][i] = 1'b1;
        else if (av && aid == i)      m_irr[k][i] = 1'b0;
      end
      m_p[k] = s;
      for (int j = 3; j > 0; j--) m_hist[k][j] = m_hist[k][j-1];
      m_hist[k][0] = ir & mask;
    end
  endtask

  function automatic int exp_id(input logic [7:0] r, input logic [7:0] m, input int pb, input int n);
    int b;
    b = (pb < n) ? pb : 0;
    for (int off = 0; off < n; off++) begin
      if (r[(b + off) % n] && !m[(b + off) % n]) return (b + off) % n;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    model_step(0, 8, 2, ir_a, lvl_a, av_a, int'(aid_a));
    model_step(1, 5, 3, {3'b0, ir_b}, {3'b0, lvl_b}, av_b, int'(aid_b));
  end

  always @(posedge clk) begin
    #2;
    if (chk_en) begin : cmp
      int e;
      e = exp_id(m_irr[0], imr_a, int'(pb_a), 8);
      check("model_irr_a", irr_a, m_irr[0]);
      check("model_int_req_a", ireq_a, e >= 0);
      check("model_req_id_a", rid_a, (e < 0) ? 0 : e);
      e = exp_id(m_irr[1], {3'b0, imr_b}, int'(pb_b), 5);
      check("model_irr_b", irr_b, m_irr[1]);
      check("model_int_req_b", ireq_b, e >= 0);
      check("model_req_id_b", rid_b, (e < 0) ? 0 : e);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ack_a(input int id);
    av_a = 1'b1; aid_a = 3'(id);
    cyc(1);
    av_a = 1'b0;
  endtask

  task automatic ack_b(input int id);
    av_b = 1'b1; aid_b = 3'(id);
    cyc(1);
    av_b = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    ir_a = '0; lvl_a = '0; imr_a = '0; pb_a = '0; av_a = 1'b0; aid_a = '0;
    ir_b = '0; lvl_b = '0; imr_b = '0; pb_b = '0; av_b = 1'b0; aid_b = '0;
    cyc(2);
    chk_en = 1'b1;
    check("rst_irr_a", irr_a, 8'h00);
    check("rst_int_req_a", ireq_a, 1'b0);
    check("rst_req_id_a", rid_a, 3'd0);
    reset = 1'b0;

    // edge capture, hold and acknowledge
    ir_a = 8'h08;
    cyc(2); check("a_lat_early", irr_a, 8'h00);
    cyc(1); check("a_capture", irr_a, 8'h08);
    ir_a = 8'h00;
    cyc(4); check("a_hold", irr_a, 8'h08);
    check("a_int_req", ireq_a, 1'b1);
    check("a_req_id", rid_a, 3'd3);
    ack_a(3);
    check("a_ack_clr", irr_a, 8'h00);
    check("a_ack_int_req", ireq_a, 1'b0);

    // rise and ack on the same edge: set wins
    ir_a = 8'h20;
    cyc(2); ack_a(5);
    check("a_set_wins", irr_a, 8'h20);
    ack_a(2);
    check("a_ack_clear_bit", irr_a, 8'h20);
    ir_a = 8'h00;
    ack_a(5);
    check("a_ack5_clr", irr_a, 8'h00);

    // level mode on ch1, then switch to edge with line high
    lvl_a = 8'h02; ir_a = 8'h02;
    cyc(3); check("lvl_set", irr_a, 8'h02);
    ack_a(1); check("lvl_ack_ignored", irr_a, 8'h02);
    ir_a = 8'h00;
    cyc(2); check("lvl_fall_early", irr_a, 8'h02);
    cyc(1); check("lvl_fall", irr_a, 8'h00);
    ir_a = 8'h02;
    cyc(3); check("lvl_reset_high", irr_a, 8'h02);
    lvl_a = 8'h00;
    cyc(4); check("mode_retain", irr_a, 8'h02);
    ack_a(1); check("edge_after_lvl_clr", irr_a, 8'h00);
    cyc(4); check("no_spurious_rise", irr_a, 8'h00);
    ir_a = 8'h00;
    cyc(3);

    // rotating priority and masking
    ir_a = 8'h91;
    cyc(3); ir_a = 8'h00;
    cyc(1); check("prio_irr", irr_a, 8'h91);
    pb_a = 3'd0; cyc(1); check("prio_b0", rid_a, 3'd0);
    pb_a = 3'd1; cyc(1); check("prio_b1", rid_a, 3'd4);
    pb_a = 3'd5; cyc(1); check("prio_b5", rid_a, 3'd7);
    pb_a = 3'd7; cyc(1); check("prio_b7", rid_a, 3'd7);
    pb_a = 3'd5; imr_a = 8'h80; cyc(1); check("prio_mask80", rid_a, 3'd0);
    imr_a = 8'h91; cyc(1);
    check("mask_all_int_req", ireq_a, 1'b0);
    check("mask_all_req_id", rid_a, 3'd0);
    check("mask_all_irr", irr_a, 8'h91);
    imr_a = 8'h00; pb_a = 3'd0;

    // reset mid-operation
    ir_a = 8'hFF;
    cyc(3); ir_a = 8'h00;
    check("pre_reset", irr_a, 8'hFF);
    reset = 1'b1; cyc(1); reset = 1'b0;
    check("rst_mid_irr", irr_a, 8'h00);
    check("rst_mid_req_id", rid_a, 3'd0);
    check("rst_mid_int_req", ireq_a, 1'b0);
    cyc(5); check("rst_stays", irr_a, 8'h00);

    // line held high through reset yields exactly one rise
    ir_a = 8'h04;
    reset = 1'b1; cyc(2); reset = 1'b0;
    cyc(2); check("thru_rst_early", irr_a, 8'h00);
    cyc(1); check("thru_rst_rise", irr_a, 8'h04);
    ack_a(2);
    cyc(3); check("thru_rst_once", irr_a, 8'h00);
    ir_a = 8'h00;
    cyc(3);

    // N=5, three-stage synchroniser
    ir_b = 5'h01;
    cyc(3); check("b_lat_early", irr_b, 5'h00);
    cyc(1); check("b_lat", irr_b, 5'h01);
    ir_b = 5'h11;
    cyc(4); check("b_irr", irr_b, 5'h11);
    ir_b = 5'h00;
    pb_b = 3'd4; cyc(1); check("b_pb4", rid_b, 3'd4);
    pb_b = 3'd6; cyc(1); check("b_pb_oor", rid_b, 3'd0);
    pb_b = 3'd3; cyc(1); check("b_pb3", rid_b, 3'd4);
    pb_b = 3'd4;
    ack_b(6); check("b_ack_oor", irr_b, 5'h11);
    ack_b(4);
    check("b_ack4_irr", irr_b, 5'h01);
    check("b_ack4_id", rid_b, 3'd0);
    cyc(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
